impl_window_checker: RTL and testbench

- Synthesizable in-circuit monitor for the timed implication "a |-> ##[MIN_DLY:MAX_DLY] b", sampled on the rising clock edge.
- It consumes the same a/b request/response pair that the stimulus side drives.
- It tracks every overlapping attempt and reports pass/fail pulses, saturating counters and a sticky failure flag.
- Instantiated beside a DUT, it gives hardware-visible protocol checking on silicon or FPGA, where simulator assertions do not exist.

---
 rtl/impl_window_checker_if.sv | 32 +++
 rtl/impl_window_checker.sv | 116 +++++++++++
 tb/tb_impl_window_checker.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/impl_window_checker_if.sv
// ============================================================================
// impl_window_checker_if : stimulus/monitor signal bundle for the window checker
// Revision: 1.0
// ============================================================================
`default_nettype none

interface impl_window_checker_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             clr;
    logic             a;
    logic             b;
    logic             pass_pulse;
    logic             fail_pulse;
    logic             fail_sticky;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             busy;

    modport master (
        output en, clr, a, b,
        input  pass_pulse, fail_pulse, fail_sticky, pass_cnt, fail_cnt, busy
    );

    modport slave (
        input  en, clr, a, b,
        output pass_pulse, fail_pulse, fail_sticky, pass_cnt, fail_cnt, busy
    );
endinterface

`default_nettype wire

// File: rtl/impl_window_checker.sv
// ============================================================================
// impl_window_checker : hardware monitor for "a |-> ##[MIN_DLY:MAX_DLY] b"
// Revision: 1.0
// ============================================================================
`default_nettype none

module impl_window_checker #(
    parameter int MIN_DLY = 2,
    parameter int MAX_DLY = 2,
    parameter int CNT_W   = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    impl_window_checker_if.slave  bus
);
    localparam int c_PCW = 6;

    logic [MAX_DLY:0]     r_pend;
    logic [MAX_DLY:0]     w_age;
    logic [MAX_DLY:0]     w_pass;
    logic [MAX_DLY:0]     w_fail;
    logic [MAX_DLY:0]     w_pend_nxt;
    logic                 w_new;
    logic [c_PCW-1:0]     w_npass;
    logic [c_PCW-1:0]     w_nfail;
    logic [CNT_W+c_PCW-1:0] w_psum;
    logic [CNT_W+c_PCW-1:0] w_fsum;
    logic [CNT_W-1:0]     w_pass_cnt_nxt;
    logic [CNT_W-1:0]     w_fail_cnt_nxt;

    logic                 r_pass_pulse;
    logic                 r_fail_pulse;
    logic                 r_fail_sticky;
    logic [CNT_W-1:0]     r_pass_cnt;
    logic [CNT_W-1:0]     r_fail_cnt;
    logic                 r_busy;

    assign w_new = bus.en & bus.a;

    // Age 0 is the attempt starting on this edge; r_pend[0] is never loaded.
    always_comb begin
        w_age    = r_pend;
        w_age[0] = r_pend[0] | w_new;
    end

    assign w_pend_nxt[0] = 1'b0;

    generate
        for (genvar g = 0; g <= MAX_DLY; g++) begin : g_age
            if (g >= MIN_DLY) begin : g_in_win
                assign w_pass[g] = w_age[g] & bus.b;
            end else begin : g_pre_win
                assign w_pass[g] = 1'b0;
            end
            if (g == MAX_DLY) begin : g_last
                assign w_fail[g] = w_age[g] & ~bus.b;
            end else begin : g_shift
                assign w_fail[g]       = 1'b0;
                assign w_pend_nxt[g+1] = w_age[g] & ~w_pass[g];
            end
        end
    endgenerate

    always_comb begin
        w_npass = '0;
        w_nfail = '0;
        for (int k = 0; k <= MAX_DLY; k++) begin
            w_npass = w_npass + {{(c_PCW-1){1'b0}}, w_pass[k]};
            w_nfail = w_nfail + {{(c_PCW-1){1'b0}}, w_fail[k]};
        end
    end

    // Saturate when the widened sum spills past the counter width.
    assign w_psum = {{c_PCW{1'b0}}, r_pass_cnt} + {{CNT_W{1'b0}}, w_npass};
    assign w_fsum = {{c_PCW{1'b0}}, r_fail_cnt} + {{CNT_W{1'b0}}, w_nfail};
    assign w_pass_cnt_nxt = (|w_psum[CNT_W+c_PCW-1:CNT_W]) ? {CNT_W{1'b1}} : w_psum[CNT_W-1:0];
    assign w_fail_cnt_nxt = (|w_fsum[CNT_W+c_PCW-1:CNT_W]) ? {CNT_W{1'b1}} : w_fsum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend        <= '0;
            r_pass_pulse  <= 1'b0;
            r_fail_pulse  <= 1'b0;
            r_fail_sticky <= 1'b0;
            r_pass_cnt    <= '0;
            r_fail_cnt    <= '0;
            r_busy        <= 1'b0;
        end else if (bus.clr) begin
            r_pend        <= '0;
            r_pass_pulse  <= 1'b0;
            r_fail_pulse  <= 1'b0;
            r_fail_sticky <= 1'b0;
            r_pass_cnt    <= '0;
            r_fail_cnt    <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_pend        <= w_pend_nxt;
            r_pass_pulse  <= |w_pass;
            r_fail_pulse  <= |w_fail;
            r_fail_sticky <= r_fail_sticky | (|w_fail);
            r_pass_cnt    <= w_pass_cnt_nxt;
            r_fail_cnt    <= w_fail_cnt_nxt;
            r_busy        <= |w_pend_nxt;
        end
    end

    assign bus.pass_pulse  = r_pass_pulse;
    assign bus.fail_pulse  = r_fail_pulse;
    assign bus.fail_sticky = r_fail_sticky;
    assign bus.pass_cnt    = r_pass_cnt;
    assign bus.fail_cnt    = r_fail_cnt;
    assign bus.busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_impl_window_checker.sv
// ============================================================================
// tb_impl_window_checker : directed checks of the window checker in four configs
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_impl_window_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic clr = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    impl_window_checker_if #(.CNT_W(16)) if22 ();
    impl_window_checker_if #(.CNT_W(16)) if13 ();
    impl_window_checker_if #(.CNT_W(16)) if12 ();
    impl_window_checker_if #(.CNT_W(2))  ifs  ();

    assign if22.en = en; assign if22.clr = clr; assign if22.a = a; assign if22.b = b;
    assign if13.en = en; assign if13.clr = clr; assign if13.a = a; assign if13.b = b;
    assign if12.en = en; assign if12.clr = clr; assign if12.a = a; assign if12.b = b;
    assign ifs.en  = en; assign ifs.clr  = clr; assign ifs.a  = a; assign ifs.b  = b;

    impl_window_checker #(.MIN_DLY(2), .MAX_DLY(2), .CNT_W(16)) u22 (.clk(clk), .rst_n(rst_n), .bus(if22));
    impl_window_checker #(.MIN_DLY(1), .MAX_DLY(3), .CNT_W(16)) u13 (.clk(clk), .rst_n(rst_n), .bus(if13));
    impl_window_checker #(.MIN_DLY(1), .MAX_DLY(2), .CNT_W(16)) u12 (.clk(clk), .rst_n(rst_n), .bus(if12));
    impl_window_checker #(.MIN_DLY(2), .MAX_DLY(2), .CNT_W(2))  usat (.clk(clk), .rst_n(rst_n), .bus(ifs));

    task automatic step(input logic av, input logic bv);
        a = av;
        b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1'b0, 1'b0);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({if22.pass_pulse, if22.fail_pulse, if22.fail_sticky, if22.busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {if22.pass_pulse, if22.fail_pulse, if22.fail_sticky, if22.busy});
        end
        n_checks++;
        if (if22.pass_cnt !== 16'd0 || if22.fail_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cnts got=%0d/%0d exp=0/0", if22.pass_cnt, if22.fail_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_trace();
        logic [10:0] va = 11'b00110100110;
        logic [10:0] vb = 11'b00010101000;
        logic [10:0] vp = 11'b00010001000;
        logic [10:0] vf = 11'b11000010000;
        do_clr();
        for (int e = 0; e <= 10; e++) begin
            step(va[e], vb[e]);
            n_checks++;
            if (if22.pass_pulse !== vp[e]) begin
                n_err++;
                $display("FAIL trace_pass e=%0d got=%b exp=%b", e, if22.pass_pulse, vp[e]);
            end
            n_checks++;
            if (if22.fail_pulse !== vf[e]) begin
                n_err++;
                $display("FAIL trace_fail e=%0d got=%b exp=%b", e, if22.fail_pulse, vf[e]);
            end
        end
        n_checks++;
        if (if22.pass_cnt !== 16'd2 || if22.fail_cnt !== 16'd3 || if22.fail_sticky !== 1'b1 || if22.busy !== 1'b0) begin
            n_err++;
            $display("FAIL trace_final got pc=%0d fc=%0d st=%b busy=%b exp pc=2 fc=3 st=1 busy=0",
                     if22.pass_cnt, if22.fail_cnt, if22.fail_sticky, if22.busy);
        end
    endtask

    task automatic test_window();
        logic [4:0] bv [3];
        logic [4:0] pv [3];
        logic [4:0] fv [3];
        bv[0] = 5'b01000; pv[0] = 5'b01000; fv[0] = 5'b00000;
        bv[1] = 5'b01100; pv[1] = 5'b00100; fv[1] = 5'b00000;
        bv[2] = 5'b00000; pv[2] = 5'b00000; fv[2] = 5'b01000;
        for (int s = 0; s < 3; s++) begin
            do_clr();
            for (int e = 0; e <= 4; e++) begin
                step(e == 0, bv[s][e]);
                n_checks++;
                if (if13.pass_pulse !== pv[s][e] || if13.fail_pulse !== fv[s][e]) begin
                    n_err++;
                    $display("FAIL window s=%0d e=%0d got p=%b f=%b exp p=%b f=%b",
                             s, e, if13.pass_pulse, if13.fail_pulse, pv[s][e], fv[s][e]);
                end
            end
            n_checks++;
            if (if13.pass_cnt !== ((s < 2) ? 16'd1 : 16'd0) || if13.fail_cnt !== ((s == 2) ? 16'd1 : 16'd0)) begin
                n_err++;
                $display("FAIL window_cnt s=%0d got pc=%0d fc=%0d", s, if13.pass_cnt, if13.fail_cnt);
            end
        end
    endtask

    task automatic test_overlap();
        logic [6:0] va = 7'b0001111;
        logic [6:0] vb = 7'b0111100;
        logic [6:0] vp = 7'b0111100;
        do_clr();
        for (int e = 0; e <= 6; e++) begin
            step(va[e], vb[e]);
            n_checks++;
            if (if22.pass_pulse !== vp[e] || if22.fail_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL overlap e=%0d got p=%b f=%b exp p=%b f=0", e, if22.pass_pulse, if22.fail_pulse, vp[e]);
            end
        end
        n_checks++;
        if (if22.pass_cnt !== 16'd4 || if22.fail_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL overlap_cnt got pc=%0d fc=%0d exp pc=4 fc=0", if22.pass_cnt, if22.fail_cnt);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] va = 4'b0011;
        logic [3:0] vb = 4'b0100;
        logic [3:0] vp = 4'b0100;
        do_clr();
        for (int e = 0; e <= 3; e++) begin
            step(va[e], vb[e]);
            n_checks++;
            if (if12.pass_pulse !== vp[e] || if12.fail_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL simul e=%0d got p=%b f=%b exp p=%b f=0", e, if12.pass_pulse, if12.fail_pulse, vp[e]);
            end
        end
        n_checks++;
        if (if12.pass_cnt !== 16'd2 || if12.fail_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL simul_cnt got pc=%0d fc=%0d exp pc=2 fc=0", if12.pass_cnt, if12.fail_cnt);
        end
    endtask

    task automatic test_control();
        do_clr();
        step(1'b1, 1'b0);
        n_checks++;
        if (if22.busy !== 1'b1) begin
            n_err++;
            $display("FAIL ctl_busy got=%b exp=1", if22.busy);
        end
        clr = 1'b1;
        step(1'b0, 1'b1);
        clr = 1'b0;
        for (int e = 2; e <= 4; e++) begin
            step(1'b0, 1'b1);
            n_checks++;
            if (if22.pass_pulse !== 1'b0 || if22.fail_pulse !== 1'b0 || if22.busy !== 1'b0) begin
                n_err++;
                $display("FAIL ctl_clr e=%0d got p=%b f=%b busy=%b exp 0 0 0",
                         e, if22.pass_pulse, if22.fail_pulse, if22.busy);
            end
        end
        n_checks++;
        if (if22.pass_cnt !== 16'd0 || if22.fail_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL ctl_clr_cnt got pc=%0d fc=%0d exp 0/0", if22.pass_cnt, if22.fail_cnt);
        end
        en = 1'b0;
        for (int e = 0; e < 4; e++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (if22.busy !== 1'b0) begin
                n_err++;
                $display("FAIL ctl_en e=%0d busy got=%b exp=0", e, if22.busy);
            end
        end
        en = 1'b1;
        for (int e = 0; e < 3; e++) step(1'b0, 1'b0);
        n_checks++;
        if (if22.fail_cnt !== 16'd0 || if22.fail_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL ctl_en_fail got fc=%0d st=%b exp 0/0", if22.fail_cnt, if22.fail_sticky);
        end
        do_clr();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_checks++;
        if (if22.fail_pulse !== 1'b1 || if22.busy !== 1'b1 || if22.fail_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL ctl_pre_rst got f=%b busy=%b fc=%0d exp 1 1 1", if22.fail_pulse, if22.busy, if22.fail_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if22.pass_pulse, if22.fail_pulse, if22.fail_sticky, if22.busy} !== 4'b0000 ||
            if22.pass_cnt !== 16'd0 || if22.fail_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL ctl_async_rst got flags=%b pc=%0d fc=%0d exp 0",
                     {if22.pass_pulse, if22.fail_pulse, if22.fail_sticky, if22.busy}, if22.pass_cnt, if22.fail_cnt);
        end
        #1 rst_n = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if (if22.fail_pulse !== 1'b0 || if22.fail_cnt !== 16'd0) begin
                n_err++;
                $display("FAIL ctl_rst_discard e=%0d got f=%b fc=%0d exp 0/0", e, if22.fail_pulse, if22.fail_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        logic       exp_pulse;
        do_clr();
        for (int e = 0; e <= 8; e++) begin
            step(e < 5, 1'b0);
            exp_pulse = (e >= 2 && e <= 6);
            exp_cnt   = (e < 2) ? 2'd0 : (e >= 4) ? 2'd3 : 2'(e - 1);
            n_checks++;
            if (ifs.fail_pulse !== exp_pulse || ifs.fail_cnt !== exp_cnt) begin
                n_err++;
                $display("FAIL sat e=%0d got f=%b fc=%0d exp f=%b fc=%0d",
                         e, ifs.fail_pulse, ifs.fail_cnt, exp_pulse, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_trace();
        test_window();
        test_overlap();
        test_simultaneous();
        test_control();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
